// File: rtl/sfr_bus_master.sv
// sfr_bus_master: CPU-side initiator that turns load/store requests into SFR bus cycles.
// Optional build macro SFR_ERR_CNT_EN adds a saturating error counter output (err_cnt).
module sfr_bus_master #(
    parameter int unsigned SFR_ADDR_WIDTH = 32,
    parameter int unsigned SFR_WIDTH      = 32,
    parameter int unsigned SFR_BASE_ADDR  = 0,
    parameter int unsigned SFR_SPACE_SIZE = 256,
    parameter int unsigned RD_WAIT_CYCLES = 1
) (
    input  logic                      sfr_clk,
    input  logic                      sys_rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SFR_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_wr,
    input  logic [SFR_WIDTH-1:0]      req_wdata,
    input  logic [SFR_WIDTH/8-1:0]    req_be,
    output logic                      rsp_valid,
    output logic [SFR_WIDTH-1:0]      rsp_rdata,
    output logic                      rsp_err,
    input  logic [SFR_WIDTH-1:0]      sfr_rd_bus,
`ifdef SFR_ERR_CNT_EN
    output logic [7:0]                err_cnt,
`endif
    output logic [SFR_ADDR_WIDTH-1:0] sys_addr,
    output logic                      sys_wr_en,
    output logic [SFR_WIDTH-1:0]      sfr_sw_value
);

    localparam int unsigned NB = SFR_WIDTH / 8;
    localparam logic [SFR_ADDR_WIDTH:0]   ADDR_LO    = (SFR_ADDR_WIDTH+1)'(SFR_BASE_ADDR);
    localparam logic [SFR_ADDR_WIDTH:0]   SPACE_EXT  = (SFR_ADDR_WIDTH+1)'(SFR_SPACE_SIZE);
    localparam logic [SFR_ADDR_WIDTH-1:0] ALIGN_MASK = SFR_ADDR_WIDTH'(NB - 1);
    localparam logic [3:0]                WAIT_LOAD  = 4'(RD_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                wait_q, wait_d;
    logic                      wr_q, wr_d;
    logic [SFR_WIDTH-1:0]      wdata_q, wdata_d;
    logic [NB-1:0]             be_q, be_d;

    logic                      req_ready_d;
    logic                      rsp_valid_d;
    logic                      rsp_err_d;
    logic [SFR_WIDTH-1:0]      rsp_rdata_d;
    logic [SFR_ADDR_WIDTH-1:0] sys_addr_d;
    logic                      sys_wr_en_d;
    logic [SFR_WIDTH-1:0]      sw_value_d;

    logic [SFR_ADDR_WIDTH:0]   addr_off;
    logic                      req_addr_err;
    logic                      accept;
    logic [SFR_WIDTH-1:0]      merged;

    // Handshake: a request transfers in the cycle where req_valid and req_ready are both
    // high; req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse that
    // cannot be stalled.
    assign accept = req_valid && req_ready;

    // Offset wraps to a huge value when req_addr is below the base, so one compare covers both bounds.
    assign addr_off     = {1'b0, req_addr} - ADDR_LO;
    assign req_addr_err = (addr_off >= SPACE_EXT) || ((req_addr & ALIGN_MASK) != '0);

    always_comb begin
        merged = sfr_rd_bus;
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        sys_addr_d  = sys_addr;
        sw_value_d  = sfr_sw_value;
        sys_wr_en_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (req_addr_err) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_wr && (req_be == '0)) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                    end else if (req_wr && (&req_be)) begin
                        state_d     = WR;
                        sys_addr_d  = req_addr;
                        sw_value_d  = req_wdata;
                        sys_wr_en_d = 1'b1;
                    end else begin
                        state_d    = RD;
                        sys_addr_d = req_addr;
                        wait_d     = WAIT_LOAD;
                    end
                end
            end
            RD: begin
                if (wait_q == 4'd0) begin
                    if (wr_q) begin
                        state_d     = WR;
                        sw_value_d  = merged;
                        sys_wr_en_d = 1'b1;
                    end else begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = sfr_rd_bus;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            sys_addr     <= '0;
            sys_wr_en    <= 1'b0;
            sfr_sw_value <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            rsp_rdata    <= rsp_rdata_d;
            sys_addr     <= sys_addr_d;
            sys_wr_en    <= sys_wr_en_d;
            sfr_sw_value <= sw_value_d;
        end
    end

`ifdef SFR_ERR_CNT_EN
    always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt <= 8'd0;
        end else if (rsp_valid && rsp_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
